// File: rtl/cpu8_out_capture.sv
`default_nettype none
// ============================================================================
// Module   : cpu8_out_capture
// Brief    : Change-detecting capture FIFO for the CPU8 result bus, drained
//            to a host over valid/ready. Optional per-entry timestamps are
//            enabled by defining CPU8_CAP_TIMESTAMP_EN.
// Revision : 1.0  initial release
// ============================================================================
module cpu8_out_capture #(
    parameter int DEPTH        = 8,
    parameter bit STOP_ON_FULL = 1'b1
) (
    input  logic                   clk,
    input  logic                   master_reset,
    input  logic [7:0]             cpu_out,
    input  logic                   cap_en,
    input  logic                   cap_clr,
    output logic [7:0]             host_data,
    output logic                   host_valid,
    input  logic                   host_ready,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   overflow,
    output logic [1:0]             state
`ifdef CPU8_CAP_TIMESTAMP_EN
    ,
    output logic [15:0]            host_ts
`endif
);

    localparam int AW = $clog2(DEPTH);
`ifdef CPU8_CAP_TIMESTAMP_EN
    localparam int EW = 24;
`else
    localparam int EW = 8;
`endif
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FROZEN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      last_q, last_d;
    logic            overflow_q, overflow_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [EW-1:0]   head_q, head_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   push_entry;
    logic            push_req;
    logic            push_ok;
    logic            pop;
    logic            full;

    assign full       = (count_q == FULL_CNT);
    assign host_valid = (count_q != '0);
    assign pop        = host_valid & host_ready & ~cap_clr;
    // A push into a full FIFO only fits when the head leaves in the same cycle.
    assign push_ok    = push_req & ~cap_clr & (~full | pop);

    // ------------------------------------------------------------------
    // Capture state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        overflow_d = overflow_q;
        push_req   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap_en) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                push_req = 1'b1;
                last_d   = cpu_out;
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                if (!cap_en) begin
                    state_d = IDLE;
                end else if (cpu_out != last_q) begin
                    push_req = 1'b1;
                    last_d   = cpu_out;
                end
            end
            default: begin
                state_d = FROZEN;
            end
        endcase

        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
            if (STOP_ON_FULL) begin
                state_d = FROZEN;
            end
        end

        if (cap_clr) begin
            state_d    = IDLE;
            overflow_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, occupancy and registered head
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (cap_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            // The new head is the entry being written this cycle when the
            // read pointer lands on the write slot; otherwise it is in memory.
            if (count_d != '0) begin
                if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
                    head_d = push_entry;
                end else begin
                    head_d = mem_q[rd_ptr_d];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge master_reset) begin
        if (master_reset) begin
            state_q    <= IDLE;
            last_q     <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

`ifdef CPU8_CAP_TIMESTAMP_EN
    logic [15:0] ts_q, ts_d;

    // Free-running stamp, zeroed on the IDLE->ARMED transition so the
    // baseline entry always carries 0.
    always_comb begin
        ts_d = ts_q + 16'd1;
        if ((state_q == IDLE) && (state_d == ARMED)) begin
            ts_d = 16'd0;
        end
    end

    always_ff @(posedge clk or posedge master_reset) begin
        if (master_reset) begin
            ts_q <= 16'd0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign push_entry = {cpu_out, ts_q};
    assign host_ts    = head_q[15:0];
`else
    assign push_entry = cpu_out;
`endif

    assign host_data = head_q[EW-1 -: 8];
    assign fill      = count_q;
    assign overflow  = overflow_q;
    assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu8_out_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu8_out_capture
// Brief    : Directed scoreboard bench for cpu8_out_capture (DEPTH=8,
//            STOP_ON_FULL=1); covers timestamps when CPU8_CAP_TIMESTAMP_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu8_out_capture;

    logic       clk = 1'b0;
    logic       master_reset;
    logic [7:0] cpu_out;
    logic       cap_en;
    logic       cap_clr;
    logic [7:0] host_data;
    logic       host_valid;
    logic       host_ready;
    logic [3:0] fill;
    logic       overflow;
    logic [1:0] state;
`ifdef CPU8_CAP_TIMESTAMP_EN
    logic [15:0] host_ts;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q [$];

    cpu8_out_capture #(.DEPTH(8), .STOP_ON_FULL(1'b1)) dut (
        .clk          (clk),
        .master_reset (master_reset),
        .cpu_out      (cpu_out),
        .cap_en       (cap_en),
        .cap_clr      (cap_clr),
        .host_data    (host_data),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .fill         (fill),
        .overflow     (overflow),
        .state        (state)
`ifdef CPU8_CAP_TIMESTAMP_EN
        ,
        .host_ts      (host_ts)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_change(input logic [7:0] v, input bit captured);
        cpu_out = v;
        if (captured) exp_q.push_back(v);
        tick();
    endtask

    // Flush with cap_clr, then re-arm with v as the baseline value.
    task automatic arm(input logic [7:0] v);
        host_ready = 1'b0;
        cap_en     = 1'b0;
        cap_clr    = 1'b1;
        tick();
        cap_clr = 1'b0;
        chk("clr_fill", fill, 0);
        chk("clr_ovf", overflow, 0);
        chk("clr_state", state, 0);
        chk("clr_valid", host_valid, 0);
        exp_q.delete();
        cap_en  = 1'b1;
        cpu_out = v;
        tick();
        chk("arm_state", state, 1);
        exp_q.push_back(v);
        tick();
        chk("cap_state", state, 2);
    endtask

    task automatic drain(input int n);
        int waits;
        host_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            waits = 0;
            while (host_valid !== 1'b1 && waits < 20) begin
                tick();
                waits++;
            end
            if (host_valid !== 1'b1) begin
                chk("drain_timeout", host_valid, 1);
                break;
            end
            if (exp_q.size() == 0) begin
                chk("drain_extra", host_valid, 0);
                break;
            end
            chk("drain_data", host_data, exp_q.pop_front());
            tick();
        end
        host_ready = 1'b0;
    endtask

    initial begin
        master_reset = 1'b1;
        cpu_out      = 8'h00;
        cap_en       = 1'b0;
        cap_clr      = 1'b0;
        host_ready   = 1'b0;
        tick();
        tick();
        chk("rst_fill", fill, 0);
        chk("rst_valid", host_valid, 0);
        chk("rst_data", host_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_state", state, 0);

        // Baseline entry straight out of reset
        master_reset = 1'b0;
        cap_en       = 1'b1;
        host_ready   = 1'b1;
        exp_q.push_back(8'h00);
        tick();
        chk("t1_armed", state, 1);
        chk("t1_valid_armed", host_valid, 0);
        tick();
        chk("t1_valid", host_valid, 1);
        chk("t1_fill", fill, 1);
        chk("t1_state", state, 2);
        chk("t1_data", host_data, exp_q.pop_front());
        tick();
        chk("t1_fill_after", fill, 0);
        chk("t1_valid_after", host_valid, 0);

        // Change detection with repeats
        arm(8'h00);
        drive_change(8'h05, 1'b1);
        drive_change(8'h05, 1'b0);
        drive_change(8'h0A, 1'b1);
        drive_change(8'h0A, 1'b0);
        drive_change(8'h0F, 1'b1);
        chk("t2_fill", fill, 4);
        chk("t2_ovf", overflow, 0);
        drain(4);
        chk("t2_fill_empty", fill, 0);

        // Overflow freezes capture
        arm(8'h10);
        for (int i = 1; i <= 9; i++) drive_change(8'(8'h10 + i), (i <= 7));
        chk("t3_fill", fill, 8);
        chk("t3_ovf", overflow, 1);
        chk("t3_state", state, 3);
        drive_change(8'h20, 1'b0);
        chk("t3_fill_frozen", fill, 8);
        drain(8);
        chk("t3_fill_drained", fill, 0);
        chk("t3_state_drained", state, 3);
        drive_change(8'h30, 1'b0);
        chk("t3_ignored", host_valid, 0);

        // Push and pop together while full
        arm(8'h40);
        for (int i = 1; i <= 7; i++) drive_change(8'(8'h40 + i), 1'b1);
        chk("t4_fill_full", fill, 8);
        chk("t4_state", state, 2);
        host_ready = 1'b1;
        cpu_out    = 8'h48;
        chk("t4_head", host_data, exp_q.pop_front());
        exp_q.push_back(8'h48);
        tick();
        host_ready = 1'b0;
        chk("t4_fill_same", fill, 8);
        chk("t4_no_ovf", overflow, 0);
        drain(8);
        chk("t4_fill_empty", fill, 0);

        // Asynchronous reset mid-drain
        arm(8'h50);
        for (int i = 1; i <= 4; i++) drive_change(8'(8'h50 + i), 1'b1);
        chk("t5_fill", fill, 5);
        host_ready = 1'b1;
        #2;
        master_reset = 1'b1;
        #1;
        chk("t5_fill_rst", fill, 0);
        chk("t5_valid_rst", host_valid, 0);
        chk("t5_data_rst", host_data, 0);
        chk("t5_ovf_rst", overflow, 0);
        chk("t5_state_rst", state, 0);
        master_reset = 1'b0;
        host_ready   = 1'b0;
        exp_q.delete();
        tick();

`ifdef CPU8_CAP_TIMESTAMP_EN
        // Stamps relative to the ARMED cycle
        arm(8'h60);
        tick();
        tick();
        cpu_out = 8'h61;
        repeat (7) tick();
        cpu_out = 8'h62;
        tick();
        chk("t6_fill", fill, 3);
        host_ready = 1'b1;
        chk("t6_ts0", host_ts, 16'd0);
        chk("t6_d0", host_data, 8'h60);
        tick();
        chk("t6_ts3", host_ts, 16'd3);
        chk("t6_d1", host_data, 8'h61);
        tick();
        chk("t6_ts10", host_ts, 16'd10);
        chk("t6_d2", host_data, 8'h62);
        tick();
        host_ready = 1'b0;
        exp_q.delete();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
